// File: rtl/setup_menu_n_pkg.sv
// Shared types, special keypad words, menu states and small helpers for setup_menu_n.
// The AUTH state exists only when SETUP_MASTER_AUTH_EN is defined.
package setup_menu_n_pkg;

    typedef logic [79:0] senhaPac_t;
    typedef logic [23:0] bcdPac_t;

    localparam logic [3:0] KEEP_F   = 4'hF;
    localparam logic [3:0] SAVE_B   = 4'hB;
    localparam logic [3:0] CANCEL_A = 4'hA;
    localparam logic [3:0] CLEAR_D  = 4'hD;
    localparam logic [3:0] BUSY_E   = 4'hE;

    localparam senhaPac_t  MASTER_DEFAULT = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [6:0] TIME_DEFAULT   = 7'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
`ifdef SETUP_MASTER_AUTH_EN
        S_AUTH,
`endif
        S_BIP_EN,
        S_BIP_T,
        S_TRC_T,
        S_SENHA,
        S_SAVE,
        S_ABORT
    } state_e;

    // A special word is one where all twenty nibbles carry the same code.
    function automatic logic is_special(input senhaPac_t v);
        logic same;
        same = 1'b1;
        for (int i = 1; i < 20; i++) begin
            if (v[i*4 +: 4] != v[3:0]) same = 1'b0;
        end
        return same;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/setup_senha_check.sv
// Combinational password format check: contiguous digit length from nibble 0 and
// a flag that the run is pure 0-9 with only F padding above it.
module setup_senha_check
    import setup_menu_n_pkg::*;
(
    input  senhaPac_t  value,
    output logic [4:0] len,
    output logic       ok
);

    logic       run;
    logic       digits_ok;
    logic       tail_ok;
    logic [3:0] nib;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        run       = 1'b1;
        len       = '0;
        digits_ok = 1'b1;
        tail_ok   = 1'b1;
        nib       = KEEP_F;
        for (int i = 0; i < 20; i++) begin
            nib = value[i*4 +: 4];
            if (run && nib != KEEP_F) begin
                len = len + 5'd1;
                if (nib > 4'd9) digits_ok = 1'b0;
            end else begin
                run = 1'b0;
                if (nib != KEEP_F) tail_ok = 1'b0;
            end
        end
        ok = digits_ok && tail_ok;
    end

endmodule

// File: rtl/setup_menu_n.sv
// Lock configuration menu: edits a shadow config and commits it atomically on save.
// Define SETUP_MASTER_AUTH_EN to require the master password before editing.
module setup_menu_n
    import setup_menu_n_pkg::*;
#(
    parameter int N_SENHAS    = 4,
    parameter int SENHA_MIN   = 4,
    parameter int SENHA_MAX   = 12,
    parameter int T_MIN       = 5,
    parameter int T_MAX       = 60,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setup_on,
    input  logic [79:0]           digitos_value,
    input  logic                  digitos_valid,
    output logic                  display_en,
    output logic [23:0]           bcd_pac,
    output logic                  cfg_bip_status,
    output logic [6:0]            cfg_bip_time,
    output logic [6:0]            cfg_tranca_time,
    output logic [79:0]           cfg_senha_master,
    output logic [N_SENHAS*80-1:0] cfg_senhas,
    output logic                  data_setup_ok,
    output logic                  setup_abort,
    output logic                  entry_err
);

    localparam int              SW       = N_SENHAS * 80;
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]      LAST_IDX = 3'(N_SENHAS);
    localparam logic [4:0]      MIN_L    = 5'(SENHA_MIN);
    localparam logic [4:0]      MAX_L    = 5'(SENHA_MAX);
    localparam logic [6:0]      T_LO     = 7'(T_MIN);
    localparam logic [6:0]      T_HI     = 7'(T_MAX);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d, adv_state;
    logic [2:0]       idx_q, idx_d, adv_idx;
    logic             sh_bip_q, sh_bip_d;
    logic [6:0]       sh_bip_time_q, sh_bip_time_d;
    logic [6:0]       sh_trc_time_q, sh_trc_time_d;
    senhaPac_t        sh_master_q, sh_master_d;
    logic [SW-1:0]    sh_senhas_q, sh_senhas_d;
    logic             cfg_bip_q, cfg_bip_d;
    logic [6:0]       cfg_bip_time_q, cfg_bip_time_d;
    logic [6:0]       cfg_trc_time_q, cfg_trc_time_d;
    senhaPac_t        cfg_master_q, cfg_master_d;
    logic [SW-1:0]    cfg_senhas_q, cfg_senhas_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    senhaPac_t        prev_q, prev_d;
    logic             err_q, err_d, ok_q, ok_d, abort_q, abort_d;
    logic             disp_en_q, disp_en_d;
    bcdPac_t          bcd_pac_q, bcd_pac_d;
`ifdef SETUP_MASTER_AUTH_EN
    logic [1:0]       auth_fail_q, auth_fail_d;
`endif

    logic       special, in_auth, editing, tmo_hit, tm_bad, pw_ok, chk_ok;
    logic [4:0] chk_len;
    logic [3:0] nib0, nib1;
    logic [6:0] tm_val, tm_clamped;

    setup_senha_check u_check (
        .value (digitos_value),
        .len   (chk_len),
        .ok    (chk_ok)
    );

    assign nib0    = digitos_value[3:0];
    assign nib1    = digitos_value[7:4];
    assign special = is_special(digitos_value);
    assign pw_ok   = chk_ok && chk_len >= MIN_L && chk_len <= MAX_L;
`ifdef SETUP_MASTER_AUTH_EN
    assign in_auth = (state_q == S_AUTH);
`else
    assign in_auth = 1'b0;
`endif
    assign editing = !(state_q inside {S_IDLE, S_LOAD, S_SAVE, S_ABORT});
    assign tmo_hit = editing && tmo_cnt_q == TMO_LAST;

    // Two-digit time entry; a blank tens digit means units only.
    assign tm_bad     = nib0 > 4'd9 || (nib1 > 4'd9 && nib1 != KEEP_F);
    assign tm_val     = (nib1 == KEEP_F) ? {3'b0, nib0} : {3'b0, nib1} * 7'd10 + {3'b0, nib0};
    assign tm_clamped = (tm_val < T_LO) ? T_LO : (tm_val > T_HI) ? T_HI : tm_val;

    always_comb begin
        prev_d    = digitos_value;
        tmo_cnt_d = '0;
        if (editing && !(digitos_valid || digitos_value != prev_q)) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    always_comb begin
        adv_state = state_q;
        adv_idx   = idx_q;
        case (state_q)
            S_BIP_EN: adv_state = S_BIP_T;
            S_BIP_T:  adv_state = S_TRC_T;
            S_TRC_T: begin
                adv_state = S_SENHA;
                adv_idx   = '0;
            end
            S_SENHA: begin
                if (idx_q == LAST_IDX) adv_state = S_SAVE;
                else adv_idx = idx_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sh_bip_d      = sh_bip_q;
        sh_bip_time_d = sh_bip_time_q;
        sh_trc_time_d = sh_trc_time_q;
        sh_master_d   = sh_master_q;
        sh_senhas_d   = sh_senhas_q;
        err_d         = 1'b0;
`ifdef SETUP_MASTER_AUTH_EN
        auth_fail_d   = auth_fail_q;
`endif
        case (state_q)
            S_IDLE: if (setup_on) state_d = S_LOAD;
            S_LOAD: begin
                sh_bip_d      = cfg_bip_q;
                sh_bip_time_d = cfg_bip_time_q;
                sh_trc_time_d = cfg_trc_time_q;
                sh_master_d   = cfg_master_q;
                sh_senhas_d   = cfg_senhas_q;
                idx_d         = '0;
`ifdef SETUP_MASTER_AUTH_EN
                auth_fail_d   = '0;
                state_d       = S_AUTH;
`else
                state_d       = S_BIP_EN;
`endif
            end
            S_SAVE, S_ABORT: state_d = S_IDLE;
            default: begin
                if (digitos_valid) begin
                    if (special && nib0 == CANCEL_A) begin
                        state_d = S_ABORT;
                    end else if (special && nib0 == BUSY_E) begin
                        state_d = state_q;
                    end else if (special && nib0 == SAVE_B && !in_auth) begin
                        state_d = S_SAVE;
                    end else if (special && nib0 == KEEP_F && !in_auth) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        case (state_q)
`ifdef SETUP_MASTER_AUTH_EN
                            S_AUTH: begin
                                if (digitos_value == cfg_master_q) begin
                                    state_d     = S_BIP_EN;
                                    auth_fail_d = '0;
                                end else if (auth_fail_q == 2'd2) begin
                                    state_d = S_ABORT;
                                end else begin
                                    err_d       = 1'b1;
                                    auth_fail_d = auth_fail_q + 2'd1;
                                end
                            end
`endif
                            S_BIP_EN: begin
                                if (nib0 <= 4'd1) begin
                                    sh_bip_d = nib0[0];
                                    state_d  = adv_state;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            S_BIP_T, S_TRC_T: begin
                                if (tm_bad) begin
                                    err_d = 1'b1;
                                end else begin
                                    if (state_q == S_BIP_T) sh_bip_time_d = tm_clamped;
                                    else sh_trc_time_d = tm_clamped;
                                    state_d = adv_state;
                                    idx_d   = adv_idx;
                                end
                            end
                            S_SENHA: begin
                                if (special && nib0 == CLEAR_D) begin
                                    if (idx_q == 3'd0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        for (int i = 0; i < N_SENHAS; i++) begin
                                            if (idx_q == 3'(i + 1)) sh_senhas_d[i*80 +: 80] = '1;
                                        end
                                        state_d = adv_state;
                                        idx_d   = adv_idx;
                                    end
                                end else if (pw_ok) begin
                                    if (idx_q == 3'd0) sh_master_d = digitos_value;
                                    for (int i = 0; i < N_SENHAS; i++) begin
                                        if (idx_q == 3'(i + 1)) sh_senhas_d[i*80 +: 80] = digitos_value;
                                    end
                                    state_d = adv_state;
                                    idx_d   = adv_idx;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (tmo_hit) begin
                    state_d = S_ABORT;
                end
            end
        endcase

        // Commit on the edge that enters SAVE so cfg_* is already new during the ok pulse.
        cfg_bip_d      = cfg_bip_q;
        cfg_bip_time_d = cfg_bip_time_q;
        cfg_trc_time_d = cfg_trc_time_q;
        cfg_master_d   = cfg_master_q;
        cfg_senhas_d   = cfg_senhas_q;
        if (state_d == S_SAVE) begin
            cfg_bip_d      = sh_bip_d;
            cfg_bip_time_d = sh_bip_time_d;
            cfg_trc_time_d = sh_trc_time_d;
            cfg_master_d   = sh_master_d;
            cfg_senhas_d   = sh_senhas_d;
        end
        ok_d      = (state_d == S_SAVE);
        abort_d   = (state_d == S_ABORT);
        disp_en_d = (state_d != S_IDLE);
    end

    always_comb begin
        bcd_pac_d = '1;
        case (state_q)
`ifdef SETUP_MASTER_AUTH_EN
            S_AUTH:   bcd_pac_d = {4'h0, 20'hFFFFF};
`endif
            S_BIP_EN: bcd_pac_d = {4'h1, 16'hFFFF, (nib0 != KEEP_F) ? nib0 : {3'b0, sh_bip_q}};
            S_BIP_T:  bcd_pac_d = {4'h2, 12'hFFF, (nib0 != KEEP_F) ? {nib1, nib0} : to_bcd(sh_bip_time_q)};
            S_TRC_T:  bcd_pac_d = {4'h3, 12'hFFF, (nib0 != KEEP_F) ? {nib1, nib0} : to_bcd(sh_trc_time_q)};
            S_SENHA:  bcd_pac_d = {4'd4 + {1'b0, idx_q}, 20'hFFFFF};
            default:  bcd_pac_d = '1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; shadow and committed
    // config are deliberately reset so a mid-edit reset restores the factory defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            sh_bip_q       <= 1'b1;
            sh_bip_time_q  <= TIME_DEFAULT;
            sh_trc_time_q  <= TIME_DEFAULT;
            sh_master_q    <= MASTER_DEFAULT;
            sh_senhas_q    <= '1;
            cfg_bip_q      <= 1'b1;
            cfg_bip_time_q <= TIME_DEFAULT;
            cfg_trc_time_q <= TIME_DEFAULT;
            cfg_master_q   <= MASTER_DEFAULT;
            cfg_senhas_q   <= '1;
            tmo_cnt_q      <= '0;
            prev_q         <= '1;
            err_q          <= 1'b0;
            ok_q           <= 1'b0;
            abort_q        <= 1'b0;
            disp_en_q      <= 1'b0;
            bcd_pac_q      <= '1;
`ifdef SETUP_MASTER_AUTH_EN
            auth_fail_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sh_bip_q       <= sh_bip_d;
            sh_bip_time_q  <= sh_bip_time_d;
            sh_trc_time_q  <= sh_trc_time_d;
            sh_master_q    <= sh_master_d;
            sh_senhas_q    <= sh_senhas_d;
            cfg_bip_q      <= cfg_bip_d;
            cfg_bip_time_q <= cfg_bip_time_d;
            cfg_trc_time_q <= cfg_trc_time_d;
            cfg_master_q   <= cfg_master_d;
            cfg_senhas_q   <= cfg_senhas_d;
            tmo_cnt_q      <= tmo_cnt_d;
            prev_q         <= prev_d;
            err_q          <= err_d;
            ok_q           <= ok_d;
            abort_q        <= abort_d;
            disp_en_q      <= disp_en_d;
            bcd_pac_q      <= bcd_pac_d;
`ifdef SETUP_MASTER_AUTH_EN
            auth_fail_q    <= auth_fail_d;
`endif
        end
    end

    assign display_en       = disp_en_q;
    assign bcd_pac          = bcd_pac_q;
    assign cfg_bip_status   = cfg_bip_q;
    assign cfg_bip_time     = cfg_bip_time_q;
    assign cfg_tranca_time  = cfg_trc_time_q;
    assign cfg_senha_master = cfg_master_q;
    assign cfg_senhas       = cfg_senhas_q;
    assign data_setup_ok    = ok_q;
    assign setup_abort      = abort_q;
    assign entry_err        = err_q;

endmodule
